char_rotator: RTL and testbench

- Upstream stage of the 2-bit character decoders: generates per-display 2-bit character codes that scroll the message "dE1 " across NUM_DISP seven-segment displays.
- Each display's code slice feeds one decoder instance. Encoding: 0=d, 1=E, 2=1, 3=blank.
- Rotation is paced by an internal prescaler tick. Run/pause and direction come from slide switches.

---
 rtl/char_rot_pkg.sv | 25 ++
 rtl/char_rotator_tick_gen.sv | 38 +++
 rtl/char_rotator.sv | 132 +++++++++++++
 tb/tb_char_rotator.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/char_rot_pkg.sv
// ============================================================================
// Module      : char_rot_pkg
// Description : Shared character codes and reset-pattern helper for the
//               scrolling "dE1 " message generator.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package char_rot_pkg;

   typedef logic [1:0] char_code_t;

   localparam char_code_t CH_D     = 2'd0;
   localparam char_code_t CH_E     = 2'd1;
   localparam char_code_t CH_ONE   = 2'd2;
   localparam char_code_t CH_BLANK = 2'd3;

   // Display i of n starts on message character (n-1-i) mod 4.
   function automatic char_code_t init_code(input int i, input int n);
      return char_code_t'((n - 1 - i) % 4);
   endfunction

endpackage

`default_nettype wire

// File: rtl/char_rotator_tick_gen.sv
// ============================================================================
// Module      : tick_gen
// Description : Enable-gated prescaler; pulses tick on the terminal count.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tick_gen #(
   parameter int TICK_DIV = 50_000_000
) (
   input  logic CLOCK_50,
   input  logic KEY0,
   input  logic en,
   output logic tick
);

   localparam int              c_cnt_w = $clog2(TICK_DIV);
   localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(TICK_DIV - 1);

   logic [c_cnt_w-1:0] r_cnt;
   logic               w_term;

   // While disabled the count is held, so a pause resumes mid-interval.
   assign w_term = en && (r_cnt == c_last);
   assign tick   = w_term;

   always_ff @(posedge CLOCK_50 or negedge KEY0) begin
      if (!KEY0) begin
         r_cnt <= '0;
      end else if (en) begin
         if (w_term) r_cnt <= '0;
         else        r_cnt <= r_cnt + 1'b1;
      end
   end

endmodule

`default_nettype wire

// File: rtl/char_rotator.sv
// ============================================================================
// Module      : char_rotator
// Description : Scrolls "dE1 " as 2-bit character codes across NUM_DISP
//               displays. Optional single-step button: CHAR_ROTATOR_STEP_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module char_rotator
   import char_rot_pkg::*;
#(
   parameter int TICK_DIV = 50_000_000,
   parameter int NUM_DISP = 4
) (
   input  logic                        CLOCK_50,
   input  logic                        KEY0,
   input  logic                        SW_RUN,
   input  logic                        SW_DIR,
`ifdef CHAR_ROTATOR_STEP_EN
   input  logic                        KEY1,
`endif
   output logic [2*NUM_DISP-1:0]       CODE,
   output logic [$clog2(NUM_DISP)-1:0] POS,
   output logic                        TICK
);

   localparam int                  c_pos_w   = $clog2(NUM_DISP);
   localparam logic [c_pos_w-1:0]  c_pos_max = c_pos_w'(NUM_DISP - 1);

   function automatic logic [2*NUM_DISP-1:0] reset_pattern();
      logic [2*NUM_DISP-1:0] v;
      v = '0;
      for (int i = 0; i < NUM_DISP; i++) v[2*i +: 2] = init_code(i, NUM_DISP);
      return v;
   endfunction

   localparam logic [2*NUM_DISP-1:0] c_init = reset_pattern();

   logic                  r_run_m, r_run_s;
   logic                  r_dir_m, r_dir_s;
   logic [2*NUM_DISP-1:0] r_code;
   logic [c_pos_w-1:0]    r_pos;
   logic                  r_tick;
   logic                  w_tick;
   logic                  w_step;
   logic                  w_adv;
   logic [2*NUM_DISP-1:0] w_code_nxt;
   logic [c_pos_w-1:0]    w_pos_nxt;

   always_ff @(posedge CLOCK_50 or negedge KEY0) begin
      if (!KEY0) begin
         r_run_m <= 1'b0;
         r_run_s <= 1'b0;
         r_dir_m <= 1'b0;
         r_dir_s <= 1'b0;
      end else begin
         r_run_m <= SW_RUN;
         r_run_s <= r_run_m;
         r_dir_m <= SW_DIR;
         r_dir_s <= r_dir_m;
      end
   end

   tick_gen #(
      .TICK_DIV (TICK_DIV)
   ) u_tick_gen (
      .CLOCK_50 (CLOCK_50),
      .KEY0     (KEY0),
      .en       (r_run_s),
      .tick     (w_tick)
   );

`ifdef CHAR_ROTATOR_STEP_EN
   logic r_key_m, r_key_s, r_key_d;

   always_ff @(posedge CLOCK_50 or negedge KEY0) begin
      if (!KEY0) begin
         r_key_m <= 1'b0;
         r_key_s <= 1'b0;
         r_key_d <= 1'b0;
      end else begin
         r_key_m <= KEY1;
         r_key_s <= r_key_m;
         r_key_d <= r_key_s;
      end
   end

   // Press is a 1->0 transition of the synchronized button; ignored while running.
   assign w_step = r_key_d & ~r_key_s & ~r_run_s;
`else
   assign w_step = 1'b0;
`endif

   assign w_adv = w_tick | w_step;

   // Left moves each code up one display index; right moves it down.
   generate
      for (genvar i = 0; i < NUM_DISP; i++) begin : g_disp
         localparam int c_left  = (i + NUM_DISP - 1) % NUM_DISP;
         localparam int c_right = (i + 1) % NUM_DISP;
         assign w_code_nxt[2*i +: 2] = r_dir_s ? r_code[2*c_right +: 2]
                                               : r_code[2*c_left  +: 2];
      end
   endgenerate

   always_comb begin
      w_pos_nxt = r_pos;
      if (r_dir_s) w_pos_nxt = (r_pos == '0)        ? c_pos_max : r_pos - 1'b1;
      else         w_pos_nxt = (r_pos == c_pos_max) ? '0        : r_pos + 1'b1;
   end

   always_ff @(posedge CLOCK_50 or negedge KEY0) begin
      if (!KEY0) begin
         r_code <= c_init;
         r_pos  <= '0;
         r_tick <= 1'b0;
      end else begin
         r_tick <= w_adv;
         if (w_adv) begin
            r_code <= w_code_nxt;
            r_pos  <= w_pos_nxt;
         end
      end
   end

   assign CODE = r_code;
   assign POS  = r_pos;
   assign TICK = r_tick;

endmodule

`default_nettype wire

// File: tb/tb_char_rotator.sv
// ============================================================================
// Module      : tb_char_rotator
// Description : Randomized self-checking bench for char_rotator against a
//               rotation-offset reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_char_rotator;

   localparam int c_div = 4;
   localparam int c_n   = 4;

   logic             CLOCK_50 = 1'b0;
   logic             KEY0     = 1'b0;
   logic             SW_RUN   = 1'b0;
   logic             SW_DIR   = 1'b0;
`ifdef CHAR_ROTATOR_STEP_EN
   logic             KEY1     = 1'b1;
`endif
   logic [2*c_n-1:0] CODE;
   logic [1:0]       POS;
   logic             TICK;

   int total = 0;
   int bad   = 0;

   // reference model state
   int   m_pos, m_cnt;
   logic m_tick;
   logic m_run_p1, m_run_s, m_dir_p1, m_dir_s;
   logic m_key_p1, m_key_s, m_key_d;

   logic [7:0] q_codes[$];

   always #5 CLOCK_50 = ~CLOCK_50;

   char_rotator #(
      .TICK_DIV (c_div),
      .NUM_DISP (c_n)
   ) dut (
      .CLOCK_50 (CLOCK_50),
      .KEY0     (KEY0),
      .SW_RUN   (SW_RUN),
      .SW_DIR   (SW_DIR),
`ifdef CHAR_ROTATOR_STEP_EN
      .KEY1     (KEY1),
`endif
      .CODE     (CODE),
      .POS      (POS),
      .TICK     (TICK)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
      end
   endtask

   // Message as seen after net rotation pos: display i shows the character
   // that started on display (i-pos) mod N.
   function automatic logic [2*c_n-1:0] exp_code(input int pos);
      logic [2*c_n-1:0] v;
      int src;
      v = '0;
      for (int i = 0; i < c_n; i++) begin
         src = ((i - pos) % c_n + c_n) % c_n;
         v[2*i +: 2] = 2'((c_n - 1 - src) % 4);
      end
      return v;
   endfunction

   task automatic model_reset();
      m_pos = 0; m_cnt = 0; m_tick = 1'b0;
      m_run_p1 = 1'b0; m_run_s = 1'b0; m_dir_p1 = 1'b0; m_dir_s = 1'b0;
      m_key_p1 = 1'b0; m_key_s = 1'b0; m_key_d = 1'b0;
   endtask

   task automatic model_edge();
      logic fire, step;
      fire = m_run_s && (m_cnt == c_div - 1);
      if (m_run_s) m_cnt = fire ? 0 : m_cnt + 1;
      step = 1'b0;
`ifdef CHAR_ROTATOR_STEP_EN
      step = m_key_d && !m_key_s && !m_run_s;
      m_key_d  = m_key_s;
      m_key_s  = m_key_p1;
      m_key_p1 = KEY1;
`endif
      m_tick = fire || step;
      if (m_tick) m_pos = m_dir_s ? (m_pos + c_n - 1) % c_n : (m_pos + 1) % c_n;
      m_run_s = m_run_p1; m_run_p1 = SW_RUN;
      m_dir_s = m_dir_p1; m_dir_p1 = SW_DIR;
   endtask

   task automatic cyc(input logic run, input logic dir);
      SW_RUN = run;
      SW_DIR = dir;
      @(posedge CLOCK_50);
      model_edge();
      #1;
      chk("code", 32'(CODE), 32'(exp_code(m_pos)));
      chk("pos",  32'(POS),  32'(m_pos));
      chk("tick", 32'(TICK), 32'(m_tick));
   endtask

   // Async assert mid-cycle, then release between edges.
   task automatic do_reset();
      @(posedge CLOCK_50);
      #3 KEY0 = 1'b0;
      #1;
      model_reset();
      chk("rst_code", 32'(CODE), 32'h1B);
      chk("rst_pos",  32'(POS),  32'd0);
      chk("rst_tick", 32'(TICK), 32'd0);
      repeat (2) @(posedge CLOCK_50);
      @(negedge CLOCK_50);
      KEY0 = 1'b1;
   endtask

   initial begin
      logic [7:0] left_tbl[4];
      logic [7:0] right_tbl[4];
      logic       run, dir;
      int         nticks;

      left_tbl  = '{8'h6C, 8'hB1, 8'hC6, 8'h1B};
      right_tbl = '{8'hC6, 8'hB1, 8'h6C, 8'h1B};

      model_reset();
      repeat (3) @(posedge CLOCK_50);
      @(negedge CLOCK_50);
      KEY0 = 1'b1;

      // left rotation from reset: first tick 6 cycles in, then every 4
      q_codes.delete();
      for (int c = 0; c < 40; c++) begin
         cyc(1'b1, 1'b0);
         if (TICK) q_codes.push_back(CODE);
      end
      chk("left_nticks", 32'(q_codes.size()), 32'd9);
      for (int k = 0; k < q_codes.size() && k < 9; k++)
         chk("left_seq", 32'(q_codes[k]), 32'(left_tbl[k % 4]));

      // reset in the middle of a count
      cyc(1'b1, 1'b0);
      do_reset();

      q_codes.delete();
      for (int c = 0; c < 30; c++) begin
         cyc(1'b1, 1'b1);
         if (TICK) q_codes.push_back(CODE);
      end
      chk("right_nticks", 32'(q_codes.size()), 32'd7);
      for (int k = 0; k < q_codes.size() && k < 7; k++)
         chk("right_seq", 32'(q_codes[k]), 32'(right_tbl[k % 4]));

      // pause with the prescaler mid-interval, then resume
      do_reset();
      for (int c = 0; c < 4; c++) cyc(1'b1, 1'b0);
      nticks = 0;
      for (int c = 0; c < 12; c++) begin
         cyc(1'b0, 1'b0);
         if (c >= 2 && TICK) nticks++;
      end
      chk("pause_noticks", 32'(nticks), 32'd0);
      for (int c = 0; c < 12; c++) cyc(1'b1, 1'b0);

      // direction flip mid-count
      for (int c = 0; c < 3; c++) cyc(1'b1, 1'b1);
      for (int c = 0; c < 12; c++) cyc(1'b1, 1'b0);

      // random run/dir activity
      run = 1'b1; dir = 1'b0;
      for (int c = 0; c < 500; c++) begin
         if ($urandom_range(7) == 0) run = ~run;
         if ($urandom_range(9) == 0) dir = ~dir;
         cyc(run, dir);
      end

`ifdef CHAR_ROTATOR_STEP_EN
      // one step per press while paused; presses ignored while running
      do_reset();
      for (int c = 0; c < 6; c++) cyc(1'b0, 1'b0);
      nticks = 0;
      KEY1 = 1'b0;
      for (int c = 0; c < 20; c++) begin cyc(1'b0, 1'b0); if (TICK) nticks++; end
      KEY1 = 1'b1;
      for (int c = 0; c < 8; c++) begin cyc(1'b0, 1'b0); if (TICK) nticks++; end
      chk("step_once", 32'(nticks), 32'd1);
      for (int c = 0; c < 4; c++) cyc(1'b1, 1'b1);
      KEY1 = 1'b0;
      for (int c = 0; c < 10; c++) cyc(1'b1, 1'b1);
      KEY1 = 1'b1;
      for (int c = 0; c < 40; c++) begin
         if ($urandom_range(5) == 0) KEY1 = ~KEY1;
         cyc(1'($urandom_range(1)), 1'($urandom_range(1)));
      end
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
